// File: rtl/spi_mm_pkg.sv
// Shared types and constants for the nRF24L01 multi-slave SPI master:
// FSM state encoding, SPI mode 0 constants and port-width helpers.
package spi_mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bc_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period counter plus one-cycle rise/fall strobes that
// mark the clk_10 edge on which sck toggles. sck idles at CPOL when disabled.
module spi_sck_gen
    import spi_mm_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          wrap;

    assign wrap   = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o = wrap && (sck_q == SPI_CPOL);
    assign fall_o = wrap && (sck_q != SPI_CPOL);
    assign sck_o  = sck_q;

    always_comb begin
        cnt_d = '0;
        sck_d = SPI_CPOL;
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            sck_d = wrap ? ~sck_q : sck_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= SPI_CPOL;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_multi_master.sv
// SPI mode 0 master serving NUM_CH nRF24L01 slaves with per-slave CSN/MISO.
// Optional build macro SPI_LOOPBACK_EN adds a loopback input routing mosi to the receiver.
module spi_multi_master
    import spi_mm_pkg::*;
#(
    parameter  int NUM_CH    = 2,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BYTES = 33,
    parameter  int CLK_DIV   = 1,
    localparam int CH_W      = ch_w(NUM_CH),
    localparam int BC_W      = bc_w(MAX_BYTES)
) (
    input  logic              clk_10,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [BC_W-1:0]   num_words,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_CH-1:0] csn,
    input  logic [NUM_CH-1:0] miso
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic              loopback
`endif
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int            BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [BC_W-1:0]   nw_q, nw_d, wcnt_q, wcnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] txsh_q, txsh_d, rxsh_q, rxsh_d, rx_data_q, rx_data_d;
    logic              mosi_q, mosi_d, rx_valid_q, rx_valid_d, err_q, err_d;
    logic              sck_rise, sck_fall, sample, shift, rx_bit, start_ok;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_i  (clk_10),
        .rst_i  (rst),
        .en_i   (state_q == ST_SHIFT),
        .sck_o  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // Mode 0: capture on the leading edge, launch the next bit on the trailing edge.
    assign sample = (SPI_CPHA == 1'b0) ? sck_rise : sck_fall;
    assign shift  = (SPI_CPHA == 1'b0) ? sck_fall : sck_rise;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = loopback ? mosi_q : miso[ch_q];
`else
    assign rx_bit = miso[ch_q];
`endif

    assign start_ok = (num_words != '0) && (32'(num_words) <= 32'(MAX_BYTES))
                   && (32'(ch_sel) < 32'(NUM_CH));

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        nw_d       = nw_q;
        wcnt_d     = wcnt_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        rx_data_d  = rx_data_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d = ST_SETUP;
                        ch_d    = ch_sel;
                        nw_d    = num_words;
                        wcnt_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOAD: begin
                // An underrun simply waits here: sck is parked low, CSN stays asserted.
                if (tx_valid) begin
                    state_d = ST_SHIFT;
                    txsh_d  = tx_data;
                    mosi_d  = tx_data[DATA_W-1];
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sample) begin
                    rxsh_d = {rxsh_q[DATA_W-2:0], rx_bit};
                    if (bit_q == LAST_BIT) begin
                        rx_data_d  = rxsh_d;
                        rx_valid_d = 1'b1;
                    end
                end
                if (shift) begin
                    txsh_d = txsh_q << 1;
                    mosi_d = txsh_q[DATA_W-2];
                    bit_d  = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        wcnt_d  = wcnt_q + BC_W'(1);
                        state_d = (wcnt_q == nw_q - BC_W'(1)) ? ST_HOLD : ST_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                mosi_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            nw_q       <= '0;
            wcnt_q     <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            nw_q       <= nw_d;
            wcnt_q     <= wcnt_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            rx_data_q  <= rx_data_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q == ST_SETUP) || (state_q == ST_LOAD)
                   || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign done     = (state_q == ST_DONE);
    assign tx_ready = (state_q == ST_LOAD);
    assign err      = err_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    always_comb begin
        csn = '1;
        if (busy) csn[ch_q] = 1'b0;
    end

endmodule

// File: tb/tb_spi_multi_master.sv
// Bench for spi_multi_master: a cycle timeline built from the transaction rules
// drives tx/miso and is compared against the DUT every cycle.
module tb_spi_multi_master;

    localparam int D  = 8;
    localparam int CD = 1;
    localparam int N  = 1024;

    logic       clk = 1'b0;
    logic       rst, start, tx_valid, tx_ready, rx_valid, busy, done, err, sck, mosi;
    logic [0:0] ch_sel;
    logic [5:0] num_words;
    logic [7:0] tx_data, rx_data;
    logic [1:0] csn, miso;
`ifdef SPI_LOOPBACK_EN
    logic       loopback;
`endif

    logic       start2, txr2, rxv2, busy2, done2, err2, sck2, mosi2;
    logic [1:0] ch2;
    logic [5:0] nw2;
    logic [7:0] rxd2;
    logic [2:0] csn2;

    spi_multi_master #(.NUM_CH(2), .DATA_W(D), .MAX_BYTES(33), .CLK_DIV(CD)) dut (
        .clk_10(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .num_words(num_words),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .err(err),
        .sck(sck), .mosi(mosi), .csn(csn), .miso(miso)
`ifdef SPI_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    // Three-slave instance: the only way to present an out-of-range channel number.
    spi_multi_master #(.NUM_CH(3), .DATA_W(D), .MAX_BYTES(33), .CLK_DIV(CD)) dut2 (
        .clk_10(clk), .rst(rst), .start(start2), .ch_sel(ch2), .num_words(nw2),
        .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(txr2),
        .rx_data(rxd2), .rx_valid(rxv2), .busy(busy2), .done(done2), .err(err2),
        .sck(sck2), .mosi(mosi2), .csn(csn2), .miso(3'b000)
`ifdef SPI_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0, len = 0, cur_ch = 0, err_cyc = -1, done_idx = -1;
    int rxv_cnt = 0, done_cnt = 0;
    bit chk_on = 1'b0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] mosi_cap;
    logic [1:0] csn_busy;

    bit         e_csnl[N], e_busy[N], e_sck[N], e_txr[N], e_rxv[N], e_done[N];
    bit         e_mchk[N], e_mosi[N], e_acc[N], e_miso[N];
    logic [7:0] e_rxd[N], e_accw[N];
    logic [7:0] tx_w[64], rx_w[64];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sck) mosi_cap <= {mosi_cap[6:0], mosi};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Timeline: start cycle, CD setup cycles, per word (stall+1) load cycles and
    // 2*D*CD shift cycles, CD hold cycles, one done cycle.
    task automatic build(input int nw, input int gw, input int glen, input bit lb);
        int i, b, ld;
        logic [7:0] rw;
        for (int j = 0; j < N; j++) begin
            e_csnl[j] = 0; e_busy[j] = 0; e_sck[j] = 0; e_txr[j] = 0; e_rxv[j] = 0;
            e_done[j] = 0; e_mchk[j] = 0; e_mosi[j] = 0; e_acc[j] = 0; e_miso[j] = 0;
            e_rxd[j] = '0; e_accw[j] = '0;
        end
        i = 1;
        repeat (CD) begin e_csnl[i] = 1; e_busy[i] = 1; i++; end
        for (int w = 0; w < nw; w++) begin
            rw = lb ? tx_w[w] : rx_w[w];
            ld = (w == gw) ? glen : 0;
            for (int g = 0; g <= ld; g++) begin
                e_csnl[i] = 1; e_busy[i] = 1; e_txr[i] = 1; e_miso[i] = rw[7];
                if (g == ld) begin e_acc[i] = 1; e_accw[i] = tx_w[w]; end
                i++;
            end
            for (int k = 0; k < 2 * D * CD; k++) begin
                b = k / (2 * CD);
                e_csnl[i] = 1; e_busy[i] = 1; e_sck[i] = ((k / CD) % 2) == 1;
                e_mchk[i] = 1; e_mosi[i] = tx_w[w][D-1-b]; e_miso[i] = rw[D-1-b];
                if (k == 2 * D * CD - CD) begin e_rxv[i] = 1; e_rxd[i] = rw; end
                i++;
            end
        end
        repeat (CD) begin e_csnl[i] = 1; e_busy[i] = 1; i++; end
        e_done[i] = 1;
        len = i + 1;
    endtask

    task automatic run_txn(input int ch, input int nw, input int gw, input int glen,
                           input bit lb, input int abort_at);
        build(nw, gw, glen, lb);
        cur_ch = ch; done_idx = -1; mosi_cap = '0;
`ifdef SPI_LOOPBACK_EN
        loopback = lb;
`endif
        t0 = cyc; chk_on = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i == 0) begin
                start = 1'b1; ch_sel = 1'(ch); num_words = 6'(nw);
            end else begin
                start = ($urandom_range(0, 7) == 0);
                ch_sel = 1'($urandom); num_words = 6'($urandom);
            end
            tx_valid = e_acc[i];
            tx_data  = e_acc[i] ? e_accw[i] : 8'($urandom);
            miso     = 2'($urandom);
            if (!lb) miso[ch] = e_miso[i];
            if (i == abort_at) begin
                chk_on = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("abort_csn", csn, 2'b11);
                chk("abort_sck", sck, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_txr", tx_ready, 0);
                chk("abort_rxd", rx_data, 0);
                chk("abort_mosi", mosi, 0);
                last_rx = 8'h00;
                start = 1'b0; tx_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk_on = 1'b0; start = 1'b0; tx_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        int i;
        logic [1:0] ec;
        if (!rst) begin
            if (rx_valid) rxv_cnt++;
            if (done) done_cnt++;
            if (busy) csn_busy = csn;
            if (chk_on) begin
                i = cyc - t0;
                if (i >= 0 && i < N) begin
                    ec = 2'b11;
                    if (e_csnl[i]) ec[cur_ch] = 1'b0;
                    if (e_rxv[i]) last_rx = e_rxd[i];
                    chk("csn", csn, ec);
                    chk("busy", busy, e_busy[i]);
                    chk("sck", sck, e_sck[i]);
                    chk("tx_ready", tx_ready, e_txr[i]);
                    chk("rx_valid", rx_valid, e_rxv[i]);
                    chk("rx_data", rx_data, last_rx);
                    chk("done", done, e_done[i]);
                    chk("err_busy", err, 0);
                    if (e_mchk[i]) chk("mosi", mosi, e_mosi[i]);
                    if (done) done_idx = i;
                end
            end else begin
                chk("idle_csn", csn, 2'b11);
                chk("idle_busy", busy, 0);
                chk("idle_sck", sck, 0);
                chk("idle_txr", tx_ready, 0);
                chk("idle_done", done, 0);
                chk("idle_rxv", rx_valid, 0);
                chk("idle_rxd", rx_data, last_rx);
                chk("idle_err", err, (cyc == err_cyc) ? 1 : 0);
            end
        end
    end

    initial begin
        int d0, r0;
        rst = 1'b1; start = 1'b0; ch_sel = '0; num_words = '0; tx_data = '0;
        tx_valid = 1'b0; miso = '0; start2 = 1'b0; ch2 = '0; nw2 = '0;
`ifdef SPI_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(posedge clk); #1;
        chk("rst_csn", csn, 2'b11);   chk("rst_sck", sck, 0);    chk("rst_mosi", mosi, 0);
        chk("rst_txr", tx_ready, 0);  chk("rst_rxv", rx_valid, 0); chk("rst_rxd", rx_data, 0);
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);  chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Single word to slave 1
        tx_w[0] = 8'hA5; rx_w[0] = 8'h3C; d0 = done_cnt;
        run_txn(1, 1, -1, 0, 1'b0, -1);
        chk("t1_csn", csn_busy, 2'b01);
        chk("t1_mosi", mosi_cap, 8'hA5);
        chk("t1_rx", rx_data, 8'h3C);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_len", done_idx + 1, 21);

        // Full 33-word burst, back-to-back
        for (int w = 0; w < 33; w++) begin tx_w[w] = 8'(w); rx_w[w] = 8'($urandom); end
        r0 = rxv_cnt;
        run_txn(0, 33, -1, 0, 1'b0, -1);
        chk("t2_rxv", rxv_cnt - r0, 33);
        chk("t2_len", done_idx + 1, 565);

        // 20-cycle underrun before word 2
        for (int w = 0; w < 3; w++) begin tx_w[w] = 8'($urandom); rx_w[w] = 8'($urandom); end
        run_txn(1, 3, 1, 20, 1'b0, -1);
        chk("t3_len", done_idx + 1, 75);

        // Rejected requests
        start = 1'b1; ch_sel = 1'b0; num_words = 6'd0; err_cyc = cyc + 1;
        @(posedge clk); #1 start = 1'b0;
        chk("t4_err0", err, 1); chk("t4_csn0", csn, 2'b11); chk("t4_busy0", busy, 0);
        @(posedge clk); #1;
        start = 1'b1; ch_sel = 1'b1; num_words = 6'd34; err_cyc = cyc + 1;
        @(posedge clk); #1 start = 1'b0;
        chk("t4_err34", err, 1); chk("t4_csn34", csn, 2'b11); chk("t4_busy34", busy, 0);
        start2 = 1'b1; ch2 = 2'd3; nw2 = 6'd1;
        @(posedge clk); #1 start2 = 1'b0;
        chk("t4_err_ch", err2, 1); chk("t4_csn_ch", csn2, 3'b111); chk("t4_busy_ch", busy2, 0);
        @(posedge clk); #1;
        chk("t4_err_ch_end", err2, 0); chk("t4_busy_ch2", busy2, 0);

        // Reset during bit 4 of word 1, then a normal transaction
        for (int w = 0; w < 2; w++) begin tx_w[w] = 8'($urandom); rx_w[w] = 8'($urandom); end
        d0 = done_cnt;
        run_txn(0, 2, -1, 0, 1'b0, 1 + CD + 1 + 2 * 4 * CD + CD);
        chk("t5_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        tx_w[0] = 8'h96; rx_w[0] = 8'h69;
        run_txn(1, 1, -1, 0, 1'b0, -1);
        chk("t5_rx", rx_data, 8'h69);

        // Randomized transactions
        for (int t = 0; t < 6; t++) begin
            int nw;
            nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++) begin tx_w[w] = 8'($urandom); rx_w[w] = 8'($urandom); end
            run_txn($urandom_range(0, 1), nw, $urandom_range(0, nw - 1), $urandom_range(0, 6), 1'b0, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

`ifdef SPI_LOOPBACK_EN
        tx_w[0] = 8'h5A;
        run_txn(0, 1, -1, 0, 1'b1, -1);
        chk("t6_loopback", rx_data, 8'h5A);
        loopback = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
